// File: rtl/issue_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : issue_unit                                                  |
// | Purpose  : Same-cycle issue grants for int/ls/mult/div queues with a   |
// |            shift-register reservation of future CDB ownership.         |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module issue_unit #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_ready,
    output logic       int_issue,
    input  logic       mult_ready,
    output logic       mult_issue,
    input  logic       div_ready,
    output logic       div_issue,
    input  logic       ls_ready,
    input  logic       lsbuf_full,
    output logic       ls_issue,
    output logic [2:0] cdb_sel,
    output logic       div_busy
);

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_INT  = 2'd1;
    localparam logic [1:0] c_OWN_MULT = 2'd2;
    localparam logic [1:0] c_OWN_DIV  = 2'd3;
    localparam logic [3:0] c_DIV_LOAD = 4'(DIV_LAT - 1);

    // r_slot[k] names the CDB owner k cycles from now
    logic [1:0] r_slot [DIV_LAT];
    logic [1:0] w_slot_nxt [DIV_LAT];
    logic [3:0] r_div_cnt;
    logic       w_int_issue;
    logic       w_mult_issue;
    logic       w_div_issue;
    logic       w_ls_issue;

    assign div_busy = (r_div_cnt != 4'd0);

    // Distinct latencies mean same-cycle grants never target the same slot
    assign w_int_issue  = reset & int_ready  & (r_slot[1] == c_OWN_NONE);
    assign w_mult_issue = reset & mult_ready & (r_slot[MULT_LAT] == c_OWN_NONE);
    assign w_div_issue  = reset & div_ready  & ~div_busy;
    assign w_ls_issue   = reset & ls_ready   & ~lsbuf_full;

    assign int_issue  = w_int_issue;
    assign mult_issue = w_mult_issue;
    assign div_issue  = w_div_issue;
    assign ls_issue   = w_ls_issue;

    always_comb begin
        cdb_sel = 3'b000;
        case (r_slot[0])
            c_OWN_INT:  cdb_sel = 3'b001;
            c_OWN_MULT: cdb_sel = 3'b010;
            c_OWN_DIV:  cdb_sel = 3'b100;
            default:    cdb_sel = 3'b000;
        endcase
    end

    always_comb begin
        for (int k = 0; k < DIV_LAT - 1; k++) begin
            w_slot_nxt[k] = r_slot[k + 1];
        end
        w_slot_nxt[DIV_LAT - 1] = c_OWN_NONE;
        if (w_int_issue) begin
            w_slot_nxt[0] = c_OWN_INT;
        end
        if (w_mult_issue) begin
            w_slot_nxt[MULT_LAT - 1] = c_OWN_MULT;
        end
        if (w_div_issue) begin
            w_slot_nxt[DIV_LAT - 1] = c_OWN_DIV;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                r_slot[k] <= c_OWN_NONE;
            end
            r_div_cnt <= 4'd0;
        end else begin
            for (int k = 0; k < DIV_LAT; k++) begin
                r_slot[k] <= w_slot_nxt[k];
            end
            if (w_div_issue) begin
                r_div_cnt <= c_DIV_LOAD;
            end else if (r_div_cnt != 4'd0) begin
                r_div_cnt <= r_div_cnt - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_issue_unit                                               |
// | Purpose  : Directed vectors with a queued scoreboard for issue_unit.   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_issue_unit;

    logic       clk;
    logic       reset;
    logic       int_ready, mult_ready, div_ready, ls_ready, lsbuf_full;
    logic       int_issue, mult_issue, div_issue, ls_issue, div_busy;
    logic [2:0] cdb_sel;

    // Expected word layout: {int, mult, div, ls, busy, cdb_sel[2:0]}
    typedef struct {
        string      nm;
        logic [7:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    issue_unit #(.MULT_LAT(4), .DIV_LAT(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_ready  (int_ready),
        .int_issue  (int_issue),
        .mult_ready (mult_ready),
        .mult_issue (mult_issue),
        .div_ready  (div_ready),
        .div_issue  (div_issue),
        .ls_ready   (ls_ready),
        .lsbuf_full (lsbuf_full),
        .ls_issue   (ls_issue),
        .cdb_sel    (cdb_sel),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are settled mid-cycle, one expectation per cycle
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = q_exp.pop_front();
            act = {int_issue, mult_issue, div_issue, ls_issue, div_busy, cdb_sel};
            n_checks++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got i/m/d/l/busy/cdb=%b want %b", e.nm, act, e.exp);
            end
        end
    end

    // ins = {int_ready, mult_ready, div_ready, ls_ready, lsbuf_full}
    task automatic cyc(input string nm, input logic [4:0] ins, input logic rst_n,
                       input logic [7:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        {int_ready, mult_ready, div_ready, ls_ready, lsbuf_full} = ins;
        reset = rst_n;
        e.nm  = nm;
        e.exp = exp;
        q_exp.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        {int_ready, mult_ready, div_ready, ls_ready, lsbuf_full} = 5'b11110;

        // Reset held with every queue ready, then release
        repeat (3) cyc("reset_hold", 5'b11110, 1'b0, 8'b0000_0_000);
        cyc("reset_rel",  5'b11110, 1'b1, 8'b1111_0_000);
        cyc("rel_c1",     5'b00000, 1'b1, 8'b0000_1_001);
        cyc("rel_c2",     5'b00000, 1'b1, 8'b0000_1_000);
        cyc("rel_c3",     5'b00000, 1'b1, 8'b0000_1_000);
        cyc("rel_c4",     5'b00000, 1'b1, 8'b0000_1_010);
        cyc("rel_c5",     5'b00000, 1'b1, 8'b0000_1_000);
        cyc("rel_c6",     5'b00000, 1'b1, 8'b0000_1_000);
        cyc("rel_c7",     5'b00000, 1'b1, 8'b0000_0_100);
        cyc("rel_idle",   5'b00000, 1'b1, 8'b0000_0_000);

        // Int streaming
        cyc("int_c0",     5'b10000, 1'b1, 8'b1000_0_000);
        repeat (4) cyc("int_stream", 5'b10000, 1'b1, 8'b1000_0_001);
        cyc("int_tail",   5'b00000, 1'b1, 8'b0000_0_001);
        cyc("int_idle",   5'b00000, 1'b1, 8'b0000_0_000);

        // Collision avoidance
        cyc("col_c0",     5'b11100, 1'b1, 8'b1110_0_000);
        cyc("col_c1",     5'b10000, 1'b1, 8'b1000_1_001);
        cyc("col_c2",     5'b10000, 1'b1, 8'b1000_1_001);
        cyc("col_c3",     5'b10000, 1'b1, 8'b0000_1_001);
        cyc("col_c4",     5'b10000, 1'b1, 8'b1000_1_010);
        cyc("col_c5",     5'b10000, 1'b1, 8'b1000_1_001);
        cyc("col_c6",     5'b10000, 1'b1, 8'b0000_1_001);
        cyc("col_c7",     5'b10000, 1'b1, 8'b1000_0_100);
        cyc("col_c8",     5'b00000, 1'b1, 8'b0000_0_001);
        cyc("col_idle",   5'b00000, 1'b1, 8'b0000_0_000);

        // Divider occupancy: ready held c0..c14, then drain to the c21 writeback
        for (int i = 0; i <= 21; i++) begin
            logic       dr, ed, eb;
            logic [2:0] ec;
            dr = (i <= 14);
            ed = (i % 7 == 0) && (i <= 14);
            eb = (i % 7 != 0);
            ec = ((i % 7 == 0) && (i > 0)) ? 3'b100 : 3'b000;
            cyc("div_occ", {2'b00, dr, 2'b00}, 1'b1, {2'b00, ed, 1'b0, eb, ec});
        end
        cyc("div_idle",   5'b00000, 1'b1, 8'b0000_0_000);

        // Load/store gating alongside mult/div reservations
        cyc("ls_c0",      5'b01110, 1'b1, 8'b0111_0_000);
        cyc("ls_full",    5'b00011, 1'b1, 8'b0000_1_000);
        cyc("ls_c2",      5'b00010, 1'b1, 8'b0001_1_000);
        cyc("ls_multblk", 5'b01010, 1'b1, 8'b0001_1_000);
        cyc("ls_c4",      5'b00000, 1'b1, 8'b0000_1_010);
        cyc("ls_c5",      5'b00000, 1'b1, 8'b0000_1_000);
        cyc("ls_c6",      5'b00000, 1'b1, 8'b0000_1_000);
        cyc("ls_c7",      5'b00000, 1'b1, 8'b0000_0_100);

        // Reset mid-flight discards the pending mult writeback
        cyc("mid_c0",     5'b01000, 1'b1, 8'b0100_0_000);
        cyc("mid_c1",     5'b00000, 1'b1, 8'b0000_0_000);
        cyc("mid_rst",    5'b11000, 1'b0, 8'b0000_0_000);
        cyc("mid_c3",     5'b00000, 1'b1, 8'b0000_0_000);
        cyc("mid_c4",     5'b00000, 1'b1, 8'b0000_0_000);
        cyc("mid_c5",     5'b00000, 1'b1, 8'b0000_0_000);
        cyc("mid_int",    5'b10000, 1'b1, 8'b1000_0_000);
        cyc("mid_int_wb", 5'b00000, 1'b1, 8'b0000_0_001);

        for (int t = 0; t < 10 && q_exp.size() > 0; t++) @(posedge clk);
        if (q_exp.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
